// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator datapath types and constants
package calc_pkg;

  // Default operand width shared by the adder chain and the serial subtractor
  localparam int CALC_WIDTH = 8;

  // Serial subtractor sequencing states
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit full subtractor (difference and borrow-out)
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  // Borrow is generated when b exceeds a, or propagated when a and b are equal
  always_comb begin
    d_o    = a_i ^ b_i ^ bin_i;
    bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
  end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a-b, LSB first; optional SERIAL_SUB_OVERFLOW_EN adds overflow_o
module serial_subtractor
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             overflow_o
`endif
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Only the low WIDTH-1 result bits need storage; the MSB comes straight
  // from the full subtractor on the final edge.
  logic [WIDTH-2:0] r_sh;
  logic [WIDTH-1:0] r_next;
  logic             borrow_q;
  logic [CW-1:0]    cnt;
  logic             fs_d;
  logic             fs_bout;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             a_msb_q;
  logic             b_msb_q;
`endif

  full_subtractor u_fs (
    .a_i    (a_sh[0]),
    .b_i    (b_sh[0]),
    .bin_i  (borrow_q),
    .d_o    (fs_d),
    .bout_o (fs_bout)
  );

  assign r_next = {fs_d, r_sh};

  // Sequencer: accept in IDLE, shift one bit per clock in RUN, publish on the last bit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      borrow_q <= 1'b0;
      cnt      <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      diff_o   <= '0;
      borrow_o <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      overflow_o <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            a_sh     <= a_i;
            b_sh     <= b_i;
            r_sh     <= '0;
            borrow_q <= 1'b0;
            cnt      <= '0;
            busy_o   <= 1'b1;
            state    <= RUN;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q  <= a_i[WIDTH-1];
            b_msb_q  <= b_i[WIDTH-1];
`endif
          end
        end
        RUN: begin
          a_sh     <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh     <= {1'b0, b_sh[WIDTH-1:1]};
          r_sh     <= r_next[WIDTH-1:1];
          borrow_q <= fs_bout;
          cnt      <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= IDLE;
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
            diff_o   <= r_next;
            borrow_o <= fs_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
            // Signed overflow: operand signs differ and the result sign left a's
            overflow_o <= (a_msb_q ^ b_msb_q) & (fs_d ^ a_msb_q);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor (SERIAL_SUB_OVERFLOW_EN aware)
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         overflow;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] last_diff;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .a_i      (a),
    .b_i      (b),
    .busy_o   (busy),
    .done_o   (done),
    .diff_o   (diff),
    .borrow_o (borrow)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .overflow_o (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done with a bound; checks outputs stay frozen while running
  task automatic wait_done(input string tag, output int cycles, output int busy_cnt);
    cycles   = 0;
    busy_cnt = 0;
    do begin
      tick();
      cycles++;
      if (busy) busy_cnt++;
      if (!done) check({tag, "_hold"}, diff, last_diff);
    end while (!done && cycles < 20);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
    int cyc;
    int bc;
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_e0"}, busy, 1);
    wait_done(tag, cyc, bc);
    check({tag, "_latency"}, cyc, W);
    check({tag, "_busy_cycles"}, bc + 1, W);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_borrow"}, borrow, eb);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check({tag, "_ovf"}, overflow, eo);
`else
    if (eo !== 1'b0 && eo !== 1'b1) check({tag, "_ovf_arg"}, eo, 0);
`endif
    last_diff = ed;
    tick();
    check({tag, "_done_1cyc"}, done, 0);
  endtask

  initial begin
    int cyc;
    int bc;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    last_diff = '0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("rst_ovf", overflow, 0);
`endif
    rst_n = 1'b1;
    tick();

    // Basic subtractions
    run_op("t1_35m12", 8'h35, 8'h12, 8'h23, 1'b0, 1'b0);

    // Asynchronous abort mid-run
    a = 8'h80; b = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check("t4_abort_busy", busy, 0);
    check("t4_abort_done", done, 0);
    check("t4_abort_diff", diff, 0);
    check("t4_abort_borrow", borrow, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    last_diff = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_no_done", done, 0);
      check("t4_idle", busy, 0);
    end
    run_op("t4_10m01", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);

    run_op("t2_12m35", 8'h12, 8'h35, 8'hDD, 1'b1, 1'b0);
    run_op("t2_00m01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    run_op("t2_5am5a", 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0);

    // Start held during busy is ignored; accepted on the done cycle
    a = 8'h40; b = 8'h01; start = 1'b1;
    tick();
    a = 8'hFF; b = 8'hFF;
    last_diff = 8'h00;
    wait_done("t3_first", cyc, bc);
    check("t3_first_latency", cyc, W);
    check("t3_first_diff", diff, 8'h3F);
    check("t3_first_borrow", borrow, 0);
    last_diff = 8'h3F;
    tick();
    start = 1'b0;
    check("t3_second_busy", busy, 1);
    check("t3_second_done_low", done, 0);
    wait_done("t3_second", cyc, bc);
    check("t3_second_latency", cyc, W);
    check("t3_second_diff", diff, 8'h00);
    check("t3_second_borrow", borrow, 0);
    last_diff = 8'h00;
    tick();

    // Back-to-back with start on the done cycle
    a = 8'h09; b = 8'h03; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t5_first", cyc, bc);
    check("t5_first_diff", diff, 8'h06);
    check("t5_first_borrow", borrow, 0);
    last_diff = 8'h06;
    a = 8'h03; b = 8'h09; start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_second_busy", busy, 1);
    wait_done("t5_second", cyc, bc);
    check("t5_done_gap", cyc + 1, W + 1);
    check("t5_second_diff", diff, 8'hFA);
    check("t5_second_borrow", borrow, 1);
    last_diff = 8'hFA;
    tick();

    // Signed-overflow vectors (diff/borrow checked in every build)
    run_op("t6_80m01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op("t6_7fmff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    run_op("t6_05m03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned/two's-complement subtractor for the calculator datapath: computes a_i - b_i one bit per clock, LSB first, using a registered borrow.
- Area-lean counterpart to the ripple-carry adder chain; the calculator control FSM drives it with a start/busy/done handshake.
- Result and borrow are held stable until the next accepted start.

Parameters:
- WIDTH, 8, operand and result width in bits (WIDTH >= 2).

Ports:
- clk_i  input  1  single clock, rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- start_i  input  1  request; sampled only when busy_o = 0.
- a_i  input  WIDTH  minuend; captured on the accepting edge.
- b_i  input  WIDTH  subtrahend; captured on the accepting edge.
- busy_o  output  1  high while an operation is in progress.
- done_o  output  1  one-cycle pulse; diff_o and borrow_o are valid and updated.
- diff_o  output  WIDTH  (a - b) mod 2^WIDTH.
- borrow_o  output  1  1 when a < b, unsigned.

Behaviour:
- Interface (already decided): one clock, clk_i; reset rst_ni is asynchronous and active-low.
- Reset: state IDLE; busy_o = 0, done_o = 0, diff_o = 0, borrow_o = 0. Shift registers, counter and borrow flop are cleared.
- FSM states: IDLE and RUN.
  - IDLE -> RUN on an edge where start_i = 1. This is edge E0.
  - RUN -> IDLE on the edge that processes bit WIDTH-1. This is edge E_WIDTH.
- At E0:
  - Load a_i and b_i into shift registers.
  - Clear the borrow flop and set the bit counter to 0.
  - busy_o rises.
- Edge E_k (k = 1..WIDTH) processes bit k-1:
  - d = a ^ b ^ bin.
  - bout = (~a & b) | (~(a ^ b) & bin).
  - Shift d into the result shift register from the MSB side; shift both operands right.
  - Update the borrow flop with bout; increment the counter.
- At E_WIDTH:
  - diff_o is loaded from the completed result and borrow_o from the final bout.
  - done_o = 1 for exactly the following cycle.
  - busy_o = 0.
- Latency: WIDTH clocks from the accepting edge to results; throughput is one operation per WIDTH+1 clocks.
- start_i while busy_o = 1 is ignored; inputs captured at E0 are not disturbed.
- Back-to-back operation: start_i may be high in the cycle where done_o = 1. That start is accepted (busy_o = 0) and done_o falls normally.
- diff_o and borrow_o only change at E_WIDTH; they never expose partial results.
- The counter width is $clog2(WIDTH). Counter wrap is never reached because RUN exits at count WIDTH-1.
- Reset asserted mid-RUN aborts immediately to reset values. No done_o pulse is produced for the aborted operation.
- a == b yields diff 0 with borrow 0. Operands are not sign-interpreted except by the optional overflow feature.

Optional Feature:
- Macro SERIAL_SUB_OVERFLOW_EN.
- When defined:
  - Adds output overflow_o (1 bit, reset 0), updated only at E_WIDTH.
  - overflow_o = 1 iff the signed two's-complement subtraction overflows, i.e. a[MSB] != b[MSB] and diff[MSB] != a[MSB].
  - A sign-bit capture register is added.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package calc_pkg holds:
  - typedef sub_state_t {IDLE, RUN}.
  - Default width constant CALC_WIDTH = 8, reused by the adder chain and this block.
- One combinational sub-module, full_subtractor: inputs a_i, b_i, bin_i; outputs d_o, bout_o.
- serial_subtractor instantiates it once on the shift-register LSBs and the borrow flop.

Test Plan:
1. WIDTH=8, a=0x35, b=0x12, start pulse -> done_o exactly 8 clocks after accept; diff_o=0x23, borrow_o=0; busy_o high for 8 cycles.
2. a=0x12, b=0x35 -> diff_o=0xDD, borrow_o=1. Then a=0x00, b=0x01 -> diff_o=0xFF, borrow_o=1. Then a=0x5A, b=0x5A -> diff_o=0x00, borrow_o=0.
3. Start with a=0x40, b=0x01, then hold start_i=1 with a=0xFF, b=0xFF during busy -> first result 0x3F unaffected. The next operation starts on the done_o cycle and yields 0x00.
4. Reset rst_ni low for 1 cycle (asynchronously, mid-cycle) at bit 4 of a=0x80, b=0x01 -> all outputs 0 immediately and no done_o. A new op a=0x10, b=0x01 -> 0x0F.
5. Back-to-back ops 0x09-0x03, then 0x03-0x09 with start high on the done cycle -> results 0x06 borrow 0, then 0xFA borrow 1; done_o pulses 9 clocks apart.
6. With SERIAL_SUB_OVERFLOW_EN:
   - a=0x80, b=0x01 -> diff_o=0x7F, overflow_o=1.
   - a=0x7F, b=0xFF -> diff_o=0x80, overflow_o=1.
   - a=0x05, b=0x03 -> overflow_o=0.
